uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 107 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit framing controller driving the TX output mux select.
// Optional two-period stop field is enabled by defining UART_TX_STOP2_EN.
module uart_tx_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_data_valid,
    input  logic [7:0] i_p_data,
    input  logic       i_par_en,
    input  logic       i_par_type,
    output logic [2:0] o_sel,
    output logic       o_ser_data,
    output logic       o_par_bit,
    output logic       o_busy
);

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_START  = 3'b001;
    localparam logic [2:0] S_DATA   = 3'b010;
    localparam logic [2:0] S_PARITY = 3'b011;
    localparam logic [2:0] S_STOP   = 3'b100;

    logic [2:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_data;
    logic       r_par_en;
    logic       r_par_type;
    logic       r_busy;
`ifdef UART_TX_STOP2_EN
    logic       r_stop2;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_data     <= 8'h00;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_TX_STOP2_EN
            r_stop2    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_data_valid) begin
                        r_data     <= i_p_data;
                        r_par_en   <= i_par_en;
                        r_par_type <= i_par_type;
                        r_cnt      <= 3'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
`ifdef UART_TX_STOP2_EN
                        r_stop2    <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (i_tick) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (i_tick) begin
                        if (r_cnt == 3'd7) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (i_tick) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (i_tick) begin
`ifdef UART_TX_STOP2_EN
                        if (r_stop2) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stop2 <= 1'b1;
                        end
`else
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Parity depends only on fields latched at accept, so it is constant for the whole frame.
    assign o_par_bit  = (^r_data) ^ r_par_type;
    assign o_sel      = r_state;
    assign o_ser_data = r_data[r_cnt];
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl framing, parity and reset.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       dv;
    logic [7:0] pdata;
    logic       par_en;
    logic       par_type;
    logic [2:0] sel;
    logic       ser;
    logic       par;
    logic       busy;

    int total = 0;
    int bad   = 0;

`ifdef UART_TX_STOP2_EN
    localparam int STOP_LEN = 2;
`else
    localparam int STOP_LEN = 1;
`endif

    always #5 clk = ~clk;

    uart_tx_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick       (tick),
        .i_data_valid (dv),
        .i_p_data     (pdata),
        .i_par_en     (par_en),
        .i_par_type   (par_type),
        .o_sel        (sel),
        .o_ser_data   (ser),
        .o_par_bit    (par),
        .o_busy       (busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         period;
        logic       exp_par;
        logic [7:0] exp_bits;   // bit i = i-th transmitted data bit
        int         exp_busy;   // busy cycles with a single-period stop
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        logic [2:0] fields[12];
        logic [7:0] eb;
        logic [2:0] es;
        int nf;
        int busy_cnt;
        eb = v.exp_bits;
        fields[0] = 3'b001;
        for (int i = 1; i <= 8; i++) fields[i] = 3'b010;
        nf = 9;
        if (v.pe) begin
            fields[nf] = 3'b011;
            nf++;
        end
        for (int s = 0; s < STOP_LEN; s++) begin
            fields[nf] = 3'b100;
            nf++;
        end
        pdata    = v.d;
        par_en   = v.pe;
        par_type = v.pt;
        dv       = 1'b1;
        tick     = (v.period == 1);
        step();
        dv       = 1'b0;
        pdata    = ~v.d;
        par_en   = ~v.pe;
        par_type = ~v.pt;
        busy_cnt = 0;
        for (int k = 0; k < nf * v.period + 1; k++) begin
            es = (k / v.period < nf) ? fields[k / v.period] : 3'b000;
            check($sformatf("v%0d sel k=%0d", idx, k), sel, es);
            if (es == 3'b010)
                check($sformatf("v%0d ser k=%0d", idx, k), ser, eb[k / v.period - 1]);
            if (busy === 1'b1) busy_cnt++;
            tick = ((k % v.period) == v.period - 1);
            step();
        end
        tick = 1'b0;
        check($sformatf("v%0d busy_cycles", idx), busy_cnt, v.exp_busy + (STOP_LEN - 1) * v.period);
        check($sformatf("v%0d par_bit", idx), par, v.exp_par);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 1'b0, 8'hA5, 11};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1, 1'b1, 8'hA5, 11};
        vecs[2] = '{8'h07, 1'b0, 1'b0, 1, 1'b1, 8'h07, 10};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 4, 1'b0, 8'h3C, 44};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1, 1'b0, 8'h01, 11};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 2, 1'b1, 8'h00, 20};

        rst = 1'b1; tick = 1'b0; dv = 1'b0; pdata = 8'h00; par_en = 1'b0; par_type = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst sel", sel, 3'b000);
        check("rst busy", busy, 1'b0);
        check("rst ser", ser, 1'b0);
        check("rst par", par, 1'b0);

        for (int c = 0; c < 3; c++) begin
            tick = c[0];
            step();
            check("idle sel", sel, 3'b000);
            check("idle busy", busy, 1'b0);
        end

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        // Valid held high with 0xFF during a 0x00 frame: ignored until IDLE.
        pdata = 8'h00; par_en = 1'b0; par_type = 1'b0; dv = 1'b1; tick = 1'b1;
        step();
        pdata = 8'hFF;
        for (int k = 0; k < 9 + STOP_LEN; k++) begin
            check($sformatf("hold busy k=%0d", k), busy, 1'b1);
            if (k >= 1 && k <= 8) check($sformatf("hold ser k=%0d", k), ser, 1'b0);
            step();
        end
        check("gap sel", sel, 3'b000);
        check("gap busy", busy, 1'b0);
        step();
        check("reaccept sel", sel, 3'b001);
        check("reaccept busy", busy, 1'b1);
        dv = 1'b0;
        step();
        check("reaccept ser", ser, 1'b1);
        wait_idle("reaccept end");
        step();
        check("no requeue sel", sel, 3'b000);

        // Reset in DATA at cnt=4, then a clean restart.
        pdata = 8'hFF; par_en = 1'b1; par_type = 1'b1; dv = 1'b1; tick = 1'b1;
        step();
        dv = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("pre-rst sel", sel, 3'b010);
        check("pre-rst par", par, 1'b1);
        rst = 1'b1; dv = 1'b1;
        step();
        rst = 1'b0; dv = 1'b0;
        check("mid-rst sel", sel, 3'b000);
        check("mid-rst busy", busy, 1'b0);
        check("mid-rst ser", ser, 1'b0);
        check("mid-rst par", par, 1'b0);
        step();
        check("abandon sel", sel, 3'b000);
        pdata = 8'h5B; par_en = 1'b0; par_type = 1'b0; dv = 1'b1;
        step();
        dv = 1'b0;
        check("restart sel", sel, 3'b001);
        step();
        check("restart data sel", sel, 3'b010);
        check("restart ser", ser, 1'b1);
        wait_idle("restart end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
